// File: rtl/dnn_acc_pkg.sv
// Shared definitions for the DNN accelerator command path.
// Holds the header opcode encoding, the sequencer state encoding (also
// exported on state_tap), the run-timeout error code and a helper that
// assembles the status reply byte.
package dnn_acc_pkg;

    // Header byte bits [7:6]
    typedef enum logic [1:0] {
        OP_LOAD_WT  = 2'b00,
        OP_LOAD_DIN = 2'b01,
        OP_RUN      = 2'b10,
        OP_STATUS   = 2'b11
    } opcode_e;

    // Encodings are visible outside the block through state_tap
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_RUN     = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_TX      = 3'd6
    } state_e;

    // Reply byte sent when the PE array never signals completion
    localparam logic [7:0] ERR_TIMEOUT = 8'hEE;

    function automatic logic [7:0] status_byte(input logic       ovr,
                                               input logic       tmo,
                                               input logic [1:0] pe_sel);
        return {ovr, 3'b000, tmo, 1'b0, pe_sel};
    endfunction

endpackage

// File: rtl/dnn_byte_serializer.sv
// Byte-to-bit serializer feeding the PE array scan input.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load, din  : capture a payload byte (takes priority over shift)
//   shift      : shift left one bit this cycle
//   sp_din     : current serial bit, MSB first (a flop output, glitch-free)
//   last       : high during the 8th shift cycle of the current byte
module dnn_byte_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       shift,
    output logic       sp_din,
    output logic       last
);

    logic [7:0] sr;
    logic [2:0] bit_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= din;
            bit_cnt <= '0;
        end else if (shift) begin
            // Zeros shift in, so sp_din idles low once a byte is drained
            sr      <= {sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign sp_din = sr[7];
    assign last   = shift && (bit_cnt == 3'd7);

endmodule

// File: rtl/dnn_cmd_sequencer.sv
// UART command sequencer for a small PE array.
// Decodes header bytes (LOAD_WT, LOAD_DIN, RUN, STATUS), serializes payload
// bytes into the array, runs the array with a timeout and replies over UART.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   rx_data, rx_valid    : received byte, valid for one cycle
//   tx_data, tx_start    : reply byte and one-cycle start pulse
//   tx_busy              : transmitter busy, holds off tx_start
//   sel_pe               : PE index from the last header
//   sipo_en, sipo_en2    : weight / data scan enables
//   sp_din               : serial scan bit
//   sp_load, sp_load2    : weight / data parallel-load strobes
//   ps_load              : result capture strobe
//   pe_en                : PE array run enable
//   pe_done, pe_result   : completion pulse and result
//   state_tap            : current state code
//   overrun              : sticky flag, a byte arrived while busy
module dnn_cmd_sequencer
    import dnn_acc_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 2,
    parameter int RUN_TIMEOUT   = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [1:0] sel_pe,
    output logic       sipo_en,
    output logic       sipo_en2,
    output logic       sp_din,
    output logic       sp_load,
    output logic       sp_load2,
    output logic       ps_load,
    output logic       pe_en,
    input  logic       pe_done,
    input  logic [7:0] pe_result,
    output logic [2:0] state_tap,
    output logic       overrun
);

    localparam int              RUN_W    = $clog2(RUN_TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);
    localparam logic [3:0]      CNT_LAST = 4'(PAYLOAD_BYTES - 1);

    state_e           state_q, state_d;
    opcode_e          op_q, op_d;
    logic [1:0]       sel_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic [7:0]       reply_q, reply_d;
    logic             is_status_q, is_status_d;
    logic             last_timeout_q, last_timeout_d;
    logic             overrun_d;
    logic [7:0]       tx_data_d;
    logic             tx_start_d;
    logic             sipo_en_d, sipo_en2_d, sp_load_d, sp_load2_d;
    logic             ps_load_d, pe_en_d;
    logic             ser_load, ser_last;

    dnn_byte_serializer u_ser (
        .clk    (clk),
        .reset  (reset),
        .load   (ser_load),
        .din    (rx_data),
        .shift  (state_q == ST_SHIFT),
        .sp_din (sp_din),
        .last   (ser_last)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        sel_d          = sel_pe;
        byte_cnt_d     = byte_cnt_q;
        run_cnt_d      = run_cnt_q;
        reply_d        = reply_q;
        is_status_d    = is_status_q;
        last_timeout_d = last_timeout_q;
        overrun_d      = overrun;
        tx_data_d      = tx_data;
        tx_start_d     = 1'b0;
        ser_load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    op_d        = opcode_e'(rx_data[7:6]);
                    sel_d       = rx_data[1:0];
                    byte_cnt_d  = '0;
                    run_cnt_d   = '0;
                    is_status_d = 1'b0;
                    case (opcode_e'(rx_data[7:6]))
                        OP_LOAD_WT, OP_LOAD_DIN: state_d = ST_PAYLOAD;
                        OP_RUN:                  state_d = ST_RUN;
                        OP_STATUS: begin
                            // Status reports the PE index of this header
                            reply_d     = status_byte(overrun, last_timeout_q, rx_data[1:0]);
                            is_status_d = 1'b1;
                            state_d     = ST_TX;
                        end
                        default:                 state_d = ST_IDLE;
                    endcase
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    ser_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ser_last) begin
                    if (byte_cnt_q < CNT_LAST) begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        state_d    = ST_PAYLOAD;
                    end else begin
                        byte_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_RUN: begin
                // Completion is checked first so it wins on the timeout cycle
                if (pe_done) begin
                    reply_d = pe_result;
                    state_d = ST_CAPTURE;
                end else if (run_cnt_q == RUN_LAST) begin
                    reply_d        = ERR_TIMEOUT;
                    last_timeout_d = 1'b1;
                    state_d        = ST_TX;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: state_d = ST_TX;
            ST_TX: begin
                if (!tx_busy) begin
                    tx_data_d  = reply_q;
                    tx_start_d = 1'b1;
                    state_d    = ST_IDLE;
                    if (is_status_q) begin
                        overrun_d      = 1'b0;
                        last_timeout_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte dropped on the status send cycle must still be recorded,
        // so setting overrun overrides the clear above.
        if (rx_valid && (state_q != ST_IDLE) && (state_q != ST_PAYLOAD))
            overrun_d = 1'b1;

        // Controls are decoded from the next state and registered, so they
        // line up with state_tap and never glitch.
        sipo_en_d  = (state_d == ST_SHIFT) && (op_d == OP_LOAD_WT);
        sipo_en2_d = (state_d == ST_SHIFT) && (op_d == OP_LOAD_DIN);
        sp_load_d  = (state_d == ST_LOAD)  && (op_d == OP_LOAD_WT);
        sp_load2_d = (state_d == ST_LOAD)  && (op_d == OP_LOAD_DIN);
        ps_load_d  = (state_d == ST_CAPTURE);
        pe_en_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_LOAD_WT;
            sel_pe         <= '0;
            byte_cnt_q     <= '0;
            run_cnt_q      <= '0;
            reply_q        <= '0;
            is_status_q    <= 1'b0;
            last_timeout_q <= 1'b0;
            overrun        <= 1'b0;
            tx_data        <= '0;
            tx_start       <= 1'b0;
            sipo_en        <= 1'b0;
            sipo_en2       <= 1'b0;
            sp_load        <= 1'b0;
            sp_load2       <= 1'b0;
            ps_load        <= 1'b0;
            pe_en          <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            sel_pe         <= sel_d;
            byte_cnt_q     <= byte_cnt_d;
            run_cnt_q      <= run_cnt_d;
            reply_q        <= reply_d;
            is_status_q    <= is_status_d;
            last_timeout_q <= last_timeout_d;
            overrun        <= overrun_d;
            tx_data        <= tx_data_d;
            tx_start       <= tx_start_d;
            sipo_en        <= sipo_en_d;
            sipo_en2       <= sipo_en2_d;
            sp_load        <= sp_load_d;
            sp_load2       <= sp_load2_d;
            ps_load        <= ps_load_d;
            pe_en          <= pe_en_d;
        end
    end

    assign state_tap = state_q;

endmodule

// File: tb/tb_dnn_cmd_sequencer.sv
// Directed testbench for dnn_cmd_sequencer with hand-computed expectations.
// Inputs are driven and outputs sampled 1 time unit after the rising edge;
// pulse/level counters are sampled on the falling edge.
module tb_dnn_cmd_sequencer;

    localparam int PB = 2;
    localparam int RT = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic [1:0] sel_pe;
    logic       sipo_en, sipo_en2, sp_din, sp_load, sp_load2, ps_load, pe_en;
    logic       pe_done = 1'b0;
    logic [7:0] pe_result = 8'h00;
    logic [2:0] state_tap;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    int c_sipo = 0, c_sipo2 = 0, c_ld = 0, c_ld2 = 0, c_ps = 0, c_pe = 0, c_tx = 0;
    logic [63:0] bit_log = '0;

    dnn_cmd_sequencer #(.PAYLOAD_BYTES(PB), .RUN_TIMEOUT(RT)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .sel_pe    (sel_pe),
        .sipo_en   (sipo_en),
        .sipo_en2  (sipo_en2),
        .sp_din    (sp_din),
        .sp_load   (sp_load),
        .sp_load2  (sp_load2),
        .ps_load   (ps_load),
        .pe_en     (pe_en),
        .pe_done   (pe_done),
        .pe_result (pe_result),
        .state_tap (state_tap),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sipo_en)  c_sipo++;
        if (sipo_en2) c_sipo2++;
        if (sp_load)  c_ld++;
        if (sp_load2) c_ld2++;
        if (ps_load)  c_ps++;
        if (pe_en)    c_pe++;
        if (tx_start) c_tx++;
        if (sipo_en || sipo_en2) bit_log = {bit_log[62:0], sp_din};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({tx_data, tx_start, sel_pe, sipo_en, sipo_en2, sp_din, sp_load, sp_load2,
             ps_load, pe_en, state_tap, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tx=%h st=%0d sel=%0d ctl=%b ovr=%b want all zero",
                     tx_data, state_tap, sel_pe,
                     {tx_start, sipo_en, sipo_en2, sp_din, sp_load, sp_load2, ps_load, pe_en}, overrun);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (state_tap !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got state %0d want 0", state_tap);
        end
    endtask

    // Full two-byte load; use2 selects the data (LOAD_DIN) controls
    task automatic run_load(input string name, input logic [7:0] hdr, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [1:0] exp_sel, input logic use2);
        int s_en, s_en2, s_ld, s_ld2, s_tx;
        s_en = c_sipo; s_en2 = c_sipo2; s_ld = c_ld; s_ld2 = c_ld2; s_tx = c_tx;
        send_byte(hdr);
        n_checks++;
        if (sel_pe !== exp_sel || state_tap !== 3'd1) begin
            n_fail++;
            $display("FAIL %s_header: got sel=%0d st=%0d want sel=%0d st=1", name, sel_pe, state_tap, exp_sel);
        end
        send_byte(b0);
        n_checks++;
        if (sp_din !== b0[7] || sipo_en !== !use2 || sipo_en2 !== use2 || state_tap !== 3'd2) begin
            n_fail++;
            $display("FAIL %s_first_bit: got din=%b en=%b en2=%b st=%0d want din=%b en=%b en2=%b st=2",
                     name, sp_din, sipo_en, sipo_en2, state_tap, b0[7], !use2, use2);
        end
        repeat (8) tick();
        n_checks++;
        if (state_tap !== 3'd1) begin
            n_fail++;
            $display("FAIL %s_next_payload: got state %0d want 1", name, state_tap);
        end
        send_byte(b1);
        repeat (7) tick();
        n_checks++;
        if (state_tap !== 3'd2 || sp_load !== 1'b0 || sp_load2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early_load: got st=%0d ld=%b ld2=%b want st=2 no load",
                     name, state_tap, sp_load, sp_load2);
        end
        tick();
        n_checks++;
        if (sp_load !== !use2 || sp_load2 !== use2 || state_tap !== 3'd3) begin
            n_fail++;
            $display("FAIL %s_load_pulse: got ld=%b ld2=%b st=%0d want ld=%b ld2=%b st=3",
                     name, sp_load, sp_load2, state_tap, !use2, use2);
        end
        tick();
        n_checks++;
        if (sp_load !== 1'b0 || sp_load2 !== 1'b0 || state_tap !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_back_idle: got ld=%b ld2=%b st=%0d want 0 0 0", name, sp_load, sp_load2, state_tap);
        end
        repeat (2) tick();
        n_checks++;
        if (c_sipo - s_en !== (use2 ? 0 : 16) || c_sipo2 - s_en2 !== (use2 ? 16 : 0)) begin
            n_fail++;
            $display("FAIL %s_shift_cycles: got en=%0d en2=%0d want %0d %0d",
                     name, c_sipo - s_en, c_sipo2 - s_en2, use2 ? 0 : 16, use2 ? 16 : 0);
        end
        n_checks++;
        if (c_ld - s_ld !== (use2 ? 0 : 1) || c_ld2 - s_ld2 !== (use2 ? 1 : 0) || c_tx !== s_tx) begin
            n_fail++;
            $display("FAIL %s_pulse_counts: got ld=%0d ld2=%0d tx=%0d want %0d %0d 0",
                     name, c_ld - s_ld, c_ld2 - s_ld2, c_tx - s_tx, use2 ? 0 : 1, use2 ? 1 : 0);
        end
        n_checks++;
        if (bit_log[15:0] !== {b0, b1}) begin
            n_fail++;
            $display("FAIL %s_bits: got %h want %h", name, bit_log[15:0], {b0, b1});
        end
    endtask

    task automatic test_load_wt();
        run_load("load_wt", 8'h01, 8'hA5, 8'h3C, 2'd1, 1'b0);
    endtask

    task automatic test_load_din();
        run_load("load_din", 8'h42, 8'h96, 8'h0F, 2'd2, 1'b1);
    endtask

    task automatic test_run();
        int s_pe, s_ps, s_tx;
        s_pe = c_pe; s_ps = c_ps; s_tx = c_tx;
        send_byte(8'h83);
        n_checks++;
        if (pe_en !== 1'b1 || state_tap !== 3'd4 || sel_pe !== 2'd3) begin
            n_fail++;
            $display("FAIL run_start: got en=%b st=%0d sel=%0d want 1 4 3", pe_en, state_tap, sel_pe);
        end
        repeat (9) tick();
        pe_done = 1'b1; pe_result = 8'h7B;
        tick();
        pe_done = 1'b0; pe_result = 8'h00;
        n_checks++;
        if (state_tap !== 3'd5 || ps_load !== 1'b1 || pe_en !== 1'b0) begin
            n_fail++;
            $display("FAIL run_capture: got st=%0d ps=%b en=%b want 5 1 0", state_tap, ps_load, pe_en);
        end
        repeat (2) tick();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h7B || state_tap !== 3'd0) begin
            n_fail++;
            $display("FAIL run_reply: got start=%b data=%h st=%0d want 1 7b 0", tx_start, tx_data, state_tap);
        end
        tick();
        n_checks++;
        if (c_pe - s_pe !== 10 || c_ps - s_ps !== 1 || c_tx - s_tx !== 1) begin
            n_fail++;
            $display("FAIL run_counts: got pe=%0d ps=%0d tx=%0d want 10 1 1", c_pe - s_pe, c_ps - s_ps, c_tx - s_tx);
        end
    endtask

    task automatic test_timeout();
        int s_pe, s_tx;
        s_pe = c_pe; s_tx = c_tx;
        send_byte(8'h80);
        tx_busy = 1'b1;
        repeat (RT - 1) tick();
        n_checks++;
        if (state_tap !== 3'd4 || pe_en !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_last_run: got st=%0d en=%b want 4 1", state_tap, pe_en);
        end
        tick();
        n_checks++;
        if (state_tap !== 3'd6 || pe_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_to_tx: got st=%0d en=%b want 6 0", state_tap, pe_en);
        end
        repeat (4) tick();
        n_checks++;
        if (state_tap !== 3'd6 || c_tx !== s_tx) begin
            n_fail++;
            $display("FAIL timeout_busy_wait: got st=%0d starts=%0d want 6 0", state_tap, c_tx - s_tx);
        end
        tx_busy = 1'b0;
        tick();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hEE) begin
            n_fail++;
            $display("FAIL timeout_reply: got start=%b data=%h want 1 ee", tx_start, tx_data);
        end
        n_checks++;
        if (c_pe - s_pe !== RT) begin
            n_fail++;
            $display("FAIL timeout_pe_cycles: got %0d want %0d", c_pe - s_pe, RT);
        end
        send_byte(8'hC0);
        tick();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h08) begin
            n_fail++;
            $display("FAIL timeout_status: got start=%b data=%h want 1 08", tx_start, tx_data);
        end
    endtask

    task automatic test_timeout_race();
        send_byte(8'h81);
        repeat (RT - 1) tick();
        pe_done = 1'b1; pe_result = 8'h5A;
        tick();
        pe_done = 1'b0; pe_result = 8'h00;
        n_checks++;
        if (state_tap !== 3'd5) begin
            n_fail++;
            $display("FAIL race_capture: got state %0d want 5", state_tap);
        end
        repeat (2) tick();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL race_reply: got start=%b data=%h want 1 5a", tx_start, tx_data);
        end
        send_byte(8'hC0);
        tick();
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL race_status: got %h want 00", tx_data);
        end
    endtask

    task automatic test_overrun();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'hFF);
        n_checks++;
        if (overrun !== 1'b1 || state_tap !== 3'd2) begin
            n_fail++;
            $display("FAIL ovr_set: got ovr=%b st=%0d want 1 2", overrun, state_tap);
        end
        repeat (7) tick();
        n_checks++;
        if (state_tap !== 3'd1) begin
            n_fail++;
            $display("FAIL ovr_byte_dropped: got state %0d want 1", state_tap);
        end
        send_byte(8'h22);
        repeat (8) tick();
        n_checks++;
        if (sp_load !== 1'b1 || bit_log[15:0] !== 16'h1122) begin
            n_fail++;
            $display("FAIL ovr_load: got ld=%b bits=%h want 1 1122", sp_load, bit_log[15:0]);
        end
        tick();
        send_byte(8'hC0);
        tick();
        n_checks++;
        if (tx_data !== 8'h80 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_status: got data=%h ovr=%b want 80 0", tx_data, overrun);
        end
        // Byte arriving on the status send cycle itself
        send_byte(8'hC0);
        send_byte(8'h55);
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h00 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_tx_cycle: got start=%b data=%h ovr=%b want 1 00 1", tx_start, tx_data, overrun);
        end
        send_byte(8'hC0);
        tick();
        n_checks++;
        if (tx_data !== 8'h80 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_tx_status: got data=%h ovr=%b want 80 0", tx_data, overrun);
        end
    endtask

    task automatic test_reset_mid();
        int s_ld;
        s_ld = c_ld;
        send_byte(8'h01);
        send_byte(8'hA5);
        repeat (3) tick();
        n_checks++;
        if (sipo_en !== 1'b1 || state_tap !== 3'd2) begin
            n_fail++;
            $display("FAIL mid_pre: got en=%b st=%0d want 1 2", sipo_en, state_tap);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (sipo_en !== 1'b0 || sp_din !== 1'b0 || state_tap !== 3'd0 || sel_pe !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_async: got en=%b din=%b st=%0d sel=%0d want all 0", sipo_en, sp_din, state_tap, sel_pe);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (c_ld !== s_ld || state_tap !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_no_load: got loads=%0d st=%0d want 0 0", c_ld - s_ld, state_tap);
        end
        run_load("recover", 8'h01, 8'hA5, 8'h3C, 2'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_wt();
        test_load_din();
        test_run();
        test_timeout();
        test_timeout_race();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
